// File: rtl/mul_accum_if.sv
// ============================================================================
// Module   : mul_accum_if
// Purpose  : Product-in / frame-result-out handshake bundle for mul_accum_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mul_accum_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              prod_last;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  acc_cnt;
  logic              acc_ovf;

  modport master (
    output prod_valid, prod, prod_last, acc_ready,
    input  prod_ready, acc_valid, acc_out, acc_cnt, acc_ovf
  );

  modport slave (
    input  prod_valid, prod, prod_last, acc_ready,
    output prod_ready, acc_valid, acc_out, acc_cnt, acc_ovf
  );
endinterface

`default_nettype wire

// File: rtl/mul_accum_stage.sv
// ============================================================================
// Module   : mul_accum_stage
// Purpose  : Saturating frame accumulator for multiplier products, with beat
//            count and sticky overflow, behind valid/ready handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_accum_stage #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  input  wire logic   clr,
  mul_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] C_ACC_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_prod_ready;
  logic             w_acc_valid;
  logic             w_release;
  logic             w_beat;
  logic [ACC_W:0]   w_prod_ext;
  logic [ACC_W:0]   w_sum;

  // A beat dropped by a coincident clr must not touch any state.
  assign w_beat     = bus.prod_valid & rst_n & (r_state != S_HOLD) & ~clr;
  assign w_prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod};
  assign w_sum      = {1'b0, r_acc} + w_prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_prod_ready = 1'b0;
    w_acc_valid  = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        w_prod_ready = rst_n;
        if (w_beat) begin
          w_state_nxt = bus.prod_last ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        w_acc_valid = 1'b1;
        if (bus.acc_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clr) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clr || w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      if (w_sum[ACC_W]) begin
        r_acc <= C_ACC_MAX;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
      if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.prod_ready = w_prod_ready;
  assign bus.acc_valid  = w_acc_valid;
  assign bus.acc_out    = r_acc;
  assign bus.acc_cnt    = r_cnt;
  assign bus.acc_ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mul_accum_stage.sv
// ============================================================================
// Module   : tb_mul_accum_stage
// Purpose  : Self-checking bench for mul_accum_stage with a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_accum_stage;

  logic clk;
  logic rst_n;
  logic clr;

  int n_vec;
  int n_err;

  mul_accum_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) bus0 ();
  mul_accum_if #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) bus1 ();
  mul_accum_if #(.PROD_W(16), .ACC_W(24), .CNT_W(2)) bus2 ();

  mul_accum_stage #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus0));
  mul_accum_stage #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus1));
  mul_accum_stage #(.PROD_W(16), .ACC_W(24), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [15:0] p, input logic last);
    bus0.prod_valid = 1'b1;
    bus0.prod       = p;
    bus0.prod_last  = last;
    n_vec++;
    if (bus0.prod_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send0_ready: got %b want 1", bus0.prod_ready);
    end
    tick();
    bus0.prod_valid = 1'b0;
    bus0.prod       = 16'($urandom);
    bus0.prod_last  = 1'($urandom);
  endtask

  task automatic send1(input logic [15:0] p, input logic last);
    bus1.prod_valid = 1'b1;
    bus1.prod       = p;
    bus1.prod_last  = last;
    n_vec++;
    if (bus1.prod_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send1_ready: got %b want 1", bus1.prod_ready);
    end
    tick();
    bus1.prod_valid = 1'b0;
    bus1.prod       = 16'($urandom);
    bus1.prod_last  = 1'($urandom);
  endtask

  task automatic send2(input logic [15:0] p, input logic last);
    bus2.prod_valid = 1'b1;
    bus2.prod       = p;
    bus2.prod_last  = last;
    n_vec++;
    if (bus2.prod_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send2_ready: got %b want 1", bus2.prod_ready);
    end
    tick();
    bus2.prod_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clr   = 1'b0;
    bus0.prod_valid = 1'b0; bus0.prod = '0; bus0.prod_last = 1'b0; bus0.acc_ready = 1'b0;
    bus1.prod_valid = 1'b0; bus1.prod = '0; bus1.prod_last = 1'b0; bus1.acc_ready = 1'b0;
    bus2.prod_valid = 1'b0; bus2.prod = '0; bus2.prod_last = 1'b0; bus2.acc_ready = 1'b0;
    #3;
    n_vec++;
    if ({bus0.prod_ready, bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_dut0: got rdy=%b v=%b out=%0d cnt=%0d ovf=%b want all 0",
               bus0.prod_ready, bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf);
    end
    n_vec++;
    if ({bus1.prod_ready, bus1.acc_valid, bus1.acc_out, bus2.prod_ready, bus2.acc_valid, bus2.acc_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_dut12: got rdy1=%b v1=%b rdy2=%b v2=%b want all 0",
               bus1.prod_ready, bus1.acc_valid, bus2.prod_ready, bus2.acc_valid);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({bus0.prod_ready, bus1.prod_ready, bus2.prod_ready, bus0.acc_valid} !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b%b%b v=%b want rdy=111 v=0",
               bus0.prod_ready, bus1.prod_ready, bus2.prod_ready, bus0.acc_valid);
    end
  endtask

  task automatic test_basic_frame;
    bus0.acc_ready = 1'b1;
    send0(16'd225, 1'b0);
    send0(16'd812, 1'b0);
    send0(16'd24806, 1'b0);
    send0(16'd81, 1'b1);
    n_vec++;
    if ({bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf} !== {1'b1, 24'd25924, 8'd4, 1'b0}) begin
      n_err++;
      $display("FAIL basic_result: got v=%b out=%0d cnt=%0d ovf=%b want v=1 out=25924 cnt=4 ovf=0",
               bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf);
    end
    tick();
    n_vec++;
    if ({bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf, bus0.prod_ready} !== {1'b0, 24'd0, 8'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL basic_release: got v=%b out=%0d cnt=%0d ovf=%b rdy=%b want 0/0/0/0/1",
               bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf, bus0.prod_ready);
    end
  endtask

  task automatic test_hold;
    bus0.acc_ready = 1'b0;
    send0(16'd65025, 1'b1);
    n_vec++;
    if ({bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.prod_ready} !== {1'b1, 24'd65025, 8'd1, 1'b0}) begin
      n_err++;
      $display("FAIL hold_enter: got v=%b out=%0d cnt=%0d rdy=%b want v=1 out=65025 cnt=1 rdy=0",
               bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.prod_ready);
    end
    for (int i = 0; i < 5; i++) begin
      bus0.prod_valid = 1'b1;
      bus0.prod       = 16'($urandom);
      bus0.prod_last  = 1'($urandom);
      tick();
      n_vec++;
      if ({bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf, bus0.prod_ready} !== {1'b1, 24'd65025, 8'd1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: got v=%b out=%0d cnt=%0d ovf=%b rdy=%b want 1/65025/1/0/0",
                 i, bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf, bus0.prod_ready);
      end
    end
    bus0.prod_valid = 1'b0;
    bus0.acc_ready  = 1'b1;
    tick();
    n_vec++;
    if ({bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.prod_ready} !== {1'b0, 24'd0, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL hold_release: got v=%b out=%0d cnt=%0d rdy=%b want 0/0/0/1",
               bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.prod_ready);
    end
  endtask

  task automatic test_saturate;
    bus1.acc_ready = 1'b1;
    send1(16'd65025, 1'b0);
    send1(16'd65025, 1'b0);
    send1(16'd65025, 1'b1);
    n_vec++;
    if ({bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf} !== {1'b1, 17'd131071, 8'd3, 1'b1}) begin
      n_err++;
      $display("FAIL sat_result: got v=%b out=%0d cnt=%0d ovf=%b want v=1 out=131071 cnt=3 ovf=1",
               bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf);
    end
    tick();
    n_vec++;
    if ({bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf} !== '0) begin
      n_err++;
      $display("FAIL sat_release: got v=%b out=%0d cnt=%0d ovf=%b want all 0",
               bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf);
    end
  endtask

  task automatic test_cnt_sat;
    bus2.acc_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send2(16'd1, i == 5);
    end
    n_vec++;
    if ({bus2.acc_valid, bus2.acc_out, bus2.acc_cnt, bus2.acc_ovf} !== {1'b1, 24'd6, 2'd3, 1'b0}) begin
      n_err++;
      $display("FAIL cnt_sat: got v=%b out=%0d cnt=%0d ovf=%b want v=1 out=6 cnt=3 ovf=0",
               bus2.acc_valid, bus2.acc_out, bus2.acc_cnt, bus2.acc_ovf);
    end
    tick();
  endtask

  task automatic test_clr;
    bus0.acc_ready = 1'b1;
    send0(16'd225, 1'b0);
    bus0.prod_valid = 1'b1;
    bus0.prod       = 16'd812;
    bus0.prod_last  = 1'b0;
    clr             = 1'b1;
    tick();
    clr             = 1'b0;
    bus0.prod_valid = 1'b0;
    n_vec++;
    if ({bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf, bus0.prod_ready} !== {1'b0, 24'd0, 8'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL clr_drop: got v=%b out=%0d cnt=%0d ovf=%b rdy=%b want 0/0/0/0/1",
               bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.acc_ovf, bus0.prod_ready);
    end
    send0(16'd81, 1'b1);
    n_vec++;
    if ({bus0.acc_valid, bus0.acc_out, bus0.acc_cnt} !== {1'b1, 24'd81, 8'd1}) begin
      n_err++;
      $display("FAIL clr_next_frame: got v=%b out=%0d cnt=%0d want v=1 out=81 cnt=1",
               bus0.acc_valid, bus0.acc_out, bus0.acc_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset;
    bus0.acc_ready = 1'b0;
    send0(16'd812, 1'b1);
    n_vec++;
    if ({bus0.acc_valid, bus0.acc_out} !== {1'b1, 24'd812}) begin
      n_err++;
      $display("FAIL arst_hold: got v=%b out=%0d want v=1 out=812", bus0.acc_valid, bus0.acc_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.prod_ready} !== {1'b0, 24'd0, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL arst_immediate: got v=%b out=%0d cnt=%0d rdy=%b want all 0",
               bus0.acc_valid, bus0.acc_out, bus0.acc_cnt, bus0.prod_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus0.acc_ready = 1'b1;
    send0(16'd100, 1'b1);
    n_vec++;
    if ({bus0.acc_valid, bus0.acc_out, bus0.acc_cnt} !== {1'b1, 24'd100, 8'd1}) begin
      n_err++;
      $display("FAIL arst_new_frame: got v=%b out=%0d cnt=%0d want v=1 out=100 cnt=1",
               bus0.acc_valid, bus0.acc_out, bus0.acc_cnt);
    end
    tick();
  endtask

  // Model: a frame's result is its plain arithmetic total clamped to the
  // accumulator range, and its beat count clamped to the counter range.
  task automatic test_random_frames;
    longint      total;
    int          n;
    int          gap;
    int          wait_c;
    logic [15:0] p;
    logic [16:0] exp_out;
    logic        exp_ovf;
    bus1.acc_ready = 1'b0;
    for (int f = 0; f < 25; f++) begin
      n     = $urandom_range(1, 6);
      total = 0;
      for (int b = 0; b < n; b++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          bus1.prod_valid = 1'b0;
          bus1.prod       = 16'($urandom);
          bus1.prod_last  = 1'($urandom);
          bus1.acc_ready  = 1'($urandom);
          tick();
        end
        p = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        total += longint'(p);
        bus1.acc_ready = 1'($urandom);
        send1(p, b == n - 1);
      end
      exp_ovf = (total > 131071);
      exp_out = exp_ovf ? 17'h1FFFF : 17'(total);
      n_vec++;
      if ({bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf} !== {1'b1, exp_out, 8'(n), exp_ovf}) begin
        n_err++;
        $display("FAIL rand_frame[%0d]: got v=%b out=%0d cnt=%0d ovf=%b want v=1 out=%0d cnt=%0d ovf=%b",
                 f, bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf, exp_out, n, exp_ovf);
      end
      bus1.acc_ready = 1'b0;
      wait_c = $urandom_range(0, 3);
      for (int w = 0; w < wait_c; w++) begin
        tick();
        n_vec++;
        if ({bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf} !== {1'b1, exp_out, 8'(n), exp_ovf}) begin
          n_err++;
          $display("FAIL rand_hold[%0d]: got v=%b out=%0d cnt=%0d ovf=%b want v=1 out=%0d cnt=%0d ovf=%b",
                   f, bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf, exp_out, n, exp_ovf);
        end
      end
      bus1.acc_ready = 1'b1;
      tick();
      bus1.acc_ready = 1'b0;
      n_vec++;
      if ({bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf} !== '0) begin
        n_err++;
        $display("FAIL rand_release[%0d]: got v=%b out=%0d cnt=%0d ovf=%b want all 0",
                 f, bus1.acc_valid, bus1.acc_out, bus1.acc_cnt, bus1.acc_ovf);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic_frame();
    test_hold();
    test_saturate();
    test_cnt_sat();
    test_clr();
    test_async_reset();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
